decode_queue: RTL

Parametrised, registered successor to the combinational instruction field parser: one independent decode channel per core, each a DEPTH-entry FIFO that decodes RV32I-style words (plus custom lock and store opcodes) at enqueue and presents fully formed, sign-extended fields at its head. It sits between each core's fetch stage and its execute/lock-memory interface. It adds ready/valid back-pressure, per-channel flush, format classification, immediate assembly and illegal-opcode flagging.

---
 rtl/decode_queue.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Per-core decode FIFOs: words are decoded at enqueue and
// the head presents registered, fully formed fields.
module decode_queue #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   in_valid,
  output logic [NUM_CH-1:0]   in_ready,
  input  logic [32*NUM_CH-1:0] in_instr,
  input  logic [NUM_CH-1:0]   flush,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [7*NUM_CH-1:0] out_opcode,
  output logic [3*NUM_CH-1:0] out_funct3,
  output logic [7*NUM_CH-1:0] out_funct7,
  output logic [5*NUM_CH-1:0] out_rs1,
  output logic [5*NUM_CH-1:0] out_rs2,
  output logic [5*NUM_CH-1:0] out_rd,
  output logic [XLEN*NUM_CH-1:0] out_imm,
  output logic [3*NUM_CH-1:0] out_fmt,
  output logic [NUM_CH-1:0]   out_illegal,
  output logic [NUM_CH-1:0]   out_lock_req,
  output logic [NUM_CH-1:0]   out_lock_rel
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] F_R  = 3'd0;
  localparam logic [2:0] F_I  = 3'd1;
  localparam logic [2:0] F_SH = 3'd2;
  localparam logic [2:0] F_S  = 3'd3;
  localparam logic [2:0] F_B  = 3'd4;
  localparam logic [2:0] F_U  = 3'd5;
  localparam logic [2:0] F_J  = 3'd6;
  localparam logic [2:0] F_LK = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            lock_req;
    logic            lock_rel;
  } rec_t;

  function automatic rec_t decode(input logic [31:0] i);
    rec_t d;
    logic [6:0] op;
    logic sh_f3, is_r, is_sh, is_i, is_s;
    logic is_b, is_u, is_j, is_lq, is_lr;
    d     = '0;
    op    = i[6:0];
    // funct3 001 and 101 are the shift-immediate forms
    sh_f3 = (i[13:12] == 2'b01);
    is_r  = (op == 7'b0110011);
    is_sh = (op == 7'b0010011) & sh_f3;
    is_i  = ((op == 7'b0010011) & ~sh_f3)
          | (op == 7'b1100111)
          | (op == 7'b0000011)
          | (op == 7'b1111110);
    is_b  = (op == 7'b1100011);
    is_s  = (op == 7'b0100011) | (op == 7'b1111111);
    is_u  = (op == 7'b0110111) | (op == 7'b0010111);
    is_j  = (op == 7'b1101111);
    is_lq = (op == 7'b1000000);
    is_lr = (op == 7'b0100000);
    d.opcode = op;
    d.funct3 = i[14:12];
    unique case (1'b1)
      is_r: begin
        d.fmt    = F_R;
        d.rs1    = i[19:15];
        d.rs2    = i[24:20];
        d.rd     = i[11:7];
        d.funct7 = i[31:25];
      end
      is_sh: begin
        d.fmt    = F_SH;
        d.rs1    = i[19:15];
        d.rd     = i[11:7];
        d.funct7 = i[31:25];
        d.imm    = XLEN'(i[24:20]);
      end
      is_i: begin
        d.fmt = F_I;
        d.rs1 = i[19:15];
        d.rd  = i[11:7];
        d.imm = XLEN'($signed(i[31:20]));
      end
      is_s: begin
        d.fmt = F_S;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.imm = XLEN'($signed({i[31:25], i[11:7]}));
      end
      is_b: begin
        d.fmt = F_B;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.imm = XLEN'($signed({i[31], i[7], i[30:25],
                               i[11:8], 1'b0}));
      end
      is_u: begin
        d.fmt = F_U;
        d.rd  = i[11:7];
        d.imm = XLEN'($signed({i[31:12], 12'b0}));
      end
      is_j: begin
        d.fmt = F_J;
        d.rd  = i[11:7];
        d.imm = XLEN'($signed({i[31], i[19:12], i[20],
                               i[30:21], 1'b0}));
      end
      is_lq, is_lr: begin
        d.fmt      = F_LK;
        d.rd       = i[11:7];
        d.imm      = XLEN'(i[31:12]);
        d.lock_req = is_lq;
        d.lock_rel = is_lr;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rec_t          mem [DEPTH];
    rec_t          dec;
    rec_t          head;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic          vld;
    logic          push;
    logic          pop;

    assign dec  = decode(in_instr[32*c +: 32]);
    assign vld  = (cnt != '0);
    assign push = in_valid[c] & in_ready[c];
    assign pop  = vld & out_ready[c];

    assign in_ready[c] = rst_n & ~flush[c]
                       & (cnt < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
      end else if (flush[c]) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + PW'(1);
        if (pop)  rp <= rp + PW'(1);
        unique case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // payload needs no reset: head is masked while empty
    always_ff @(posedge clk) begin
      if (push) mem[wp] <= dec;
    end

    assign head = vld ? mem[rp] : '0;

    assign out_valid[c]             = vld;
    assign out_opcode[7*c +: 7]     = head.opcode;
    assign out_funct3[3*c +: 3]     = head.funct3;
    assign out_funct7[7*c +: 7]     = head.funct7;
    assign out_rs1[5*c +: 5]        = head.rs1;
    assign out_rs2[5*c +: 5]        = head.rs2;
    assign out_rd[5*c +: 5]         = head.rd;
    assign out_imm[XLEN*c +: XLEN]  = head.imm;
    assign out_fmt[3*c +: 3]        = head.fmt;
    assign out_illegal[c]           = head.illegal;
    assign out_lock_req[c]          = head.lock_req;
    assign out_lock_rel[c]          = head.lock_rel;
  end

endmodule
